// File: rtl/rstctl.sv
// Reset controller: synchronizes and debounces the board button, divides clk into
// clk_en pulses, holds the system in reset for RESET_HOLD pulses and freezes it on trap.
module rstctl #(
    parameter int unsigned DIV          = 4,
    parameter int unsigned RESET_HOLD   = 16,
    parameter int unsigned DEBOUNCE     = 16384,
    parameter int unsigned AUTO_RESTART = 1,
    parameter int unsigned TRAP_HOLDOFF = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       trap,
    output logic       clk_en,
    output logic       system_reset,
    output logic       trapped,
    output logic [1:0] state
);

    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned HO_W   = $clog2(TRAP_HOLDOFF + 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TRAPPED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sys_rst;
    logic              r_trapped;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_btn_pressed;
    logic [DB_W-1:0]   r_db_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HO_W-1:0]   r_ho_cnt;
    logic              w_btn_level;
    logic              w_pulse;

    // Two-flop synchronizer; idles released (button not pressed)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_level = ~r_sync2;

    // Debounce: accept a new level after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_pressed <= 1'b0;
            r_db_cnt      <= '0;
        end else if (w_btn_level == r_btn_pressed) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
            r_btn_pressed <= w_btn_level;
            r_db_cnt      <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Free-running divider; keeps counting while trapped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == DIV_W'(DIV - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_pulse = (r_div == DIV_W'(DIV - 1));

    // Hold counter counts raw pulses in HOLD while the button is released
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if ((r_state != ST_HOLD) || r_btn_pressed) begin
            r_hold_cnt <= '0;
        end else if (w_pulse && (r_hold_cnt != HOLD_W'(RESET_HOLD))) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Holdoff counter is zero outside TRAPPED, so it starts at 0 on entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ho_cnt <= '0;
        end else if (r_state != ST_TRAPPED) begin
            r_ho_cnt <= '0;
        end else if (r_ho_cnt != HO_W'(TRAP_HOLDOFF - 1)) begin
            r_ho_cnt <= r_ho_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_HOLD;
            r_sys_rst <= 1'b1;
            r_trapped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sys_rst <= (w_state_nxt == ST_HOLD);
            r_trapped <= (w_state_nxt == ST_TRAPPED);
        end
    end

    // Button press has priority over trap in RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_pulse && !r_btn_pressed && (r_hold_cnt == HOLD_W'(RESET_HOLD - 1))) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_btn_pressed) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_pulse && trap) begin
                    w_state_nxt = ST_TRAPPED;
                end
            end
            ST_TRAPPED: begin
                if (r_btn_pressed ||
                    ((AUTO_RESTART != 0) && (r_ho_cnt == HO_W'(TRAP_HOLDOFF - 1)))) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    assign clk_en       = w_pulse & (r_state != ST_TRAPPED) & ~reset;
    assign system_reset = r_sys_rst;
    assign trapped      = r_trapped;
    assign state        = r_state;

endmodule

// File: tb/tb_rstctl.sv
// Bench for rstctl: directed scenarios with hand-derived timing plus a random run
// compared against a cycle-level behavioural model of the controller rules.
module tb_rstctl;

    localparam int DIV = 4;
    localparam int RH  = 3;
    localparam int DB  = 8;
    localparam int THO = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, btn_n, trap;
    logic       clk_en, system_reset, trapped;
    logic [1:0] state;
    logic       reset2, btn_n2, trap2;
    logic       clk_en2, system_reset2, trapped2;
    logic [1:0] state2;

    rstctl #(.DIV(DIV), .RESET_HOLD(RH), .DEBOUNCE(DB), .AUTO_RESTART(1), .TRAP_HOLDOFF(THO)) u_dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .trap(trap),
        .clk_en(clk_en), .system_reset(system_reset), .trapped(trapped), .state(state)
    );

    rstctl #(.DIV(DIV), .RESET_HOLD(RH), .DEBOUNCE(DB), .AUTO_RESTART(0), .TRAP_HOLDOFF(THO)) u_dut2 (
        .clk(clk), .reset(reset2), .btn_n(btn_n2), .trap(trap2),
        .clk_en(clk_en2), .system_reset(system_reset2), .trapped(trapped2), .state(state2)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int base  = 0;
    int base2 = 0;

    // Behavioural model of DUT1: state 0=HOLD 1=RUN 2=TRAPPED
    int m_state   = 0;
    int m_div     = 0;
    int m_pulses  = 0;
    int m_ho      = 0;
    int m_run     = 0;
    bit m_pressed = 1'b0;
    bit m_s1      = 1'b1;
    bit m_s2      = 1'b1;

    always @(posedge clk) begin : model
        int nxt;
        bit pulse;
        bit level;
        if (reset) begin
            m_state = 0; m_div = 0; m_pulses = 0; m_ho = 0; m_run = 0;
            m_pressed = 1'b0; m_s1 = 1'b1; m_s2 = 1'b1;
        end else begin
            pulse = (m_div == DIV - 1);
            nxt = m_state;
            if (m_state == 0 && pulse && !m_pressed && m_pulses + 1 >= RH) nxt = 1;
            else if (m_state == 1 && m_pressed) nxt = 0;
            else if (m_state == 1 && pulse && trap) nxt = 2;
            else if (m_state == 2 && (m_pressed || m_ho + 1 >= THO)) nxt = 0;
            if (m_state != 0 || m_pressed) m_pulses = 0;
            else if (pulse) m_pulses = m_pulses + 1;
            m_ho = (m_state == 2) ? m_ho + 1 : 0;
            level = !m_s2;
            if (level == m_pressed) m_run = 0;
            else begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_pressed = level;
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_n;
            m_div = (m_div + 1) % DIV;
            m_state = nxt;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic bit phase1();
        return ((cyc - base) % DIV) == DIV - 1;
    endfunction

    task automatic test_reset();
        step(3);
        n_chk++;
        if ({state, system_reset, trapped, clk_en} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_dut1: got st=%0d rst=%b trp=%b en=%b, expected st=0 rst=1 trp=0 en=0",
                     state, system_reset, trapped, clk_en);
        end
        n_chk++;
        if ({state2, system_reset2, trapped2, clk_en2} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_dut2: got st=%0d rst=%b trp=%b en=%b, expected st=0 rst=1 trp=0 en=0",
                     state2, system_reset2, trapped2, clk_en2);
        end
    endtask

    task automatic test_boot(input int stop_at);
        logic       exp_en, exp_rst;
        logic [1:0] exp_st;
        reset = 1'b0;
        base  = cyc;
        for (int k = 1; k <= stop_at; k++) begin
            step(1);
            exp_en  = (k % 4 == 3);
            exp_rst = (k < 12);
            exp_st  = (k < 12) ? 2'd0 : 2'd1;
            n_chk++;
            if ({state, system_reset, trapped, clk_en} !== {exp_st, exp_rst, 1'b0, exp_en}) begin
                n_err++;
                $display("FAIL boot k=%0d: got st=%0d rst=%b trp=%b en=%b, expected st=%0d rst=%b trp=0 en=%b",
                         k, state, system_reset, trapped, clk_en, exp_st, exp_rst, exp_en);
            end
        end
    endtask

    task automatic test_glitch();
        btn_n = 1'b0;
        step(7);
        btn_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            n_chk++;
            if (state !== 2'd1 || system_reset !== 1'b0) begin
                n_err++;
                $display("FAIL glitch k=%0d: got st=%0d rst=%b, expected st=1 rst=0", k, state, system_reset);
            end
        end
    endtask

    task automatic test_press();
        logic [1:0] exp_st;
        int cnt = 0;
        btn_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp_st = (k < 11) ? 2'd1 : 2'd0;
            n_chk++;
            if (state !== exp_st || system_reset !== (k >= 11)) begin
                n_err++;
                $display("FAIL press k=%0d: got st=%0d rst=%b, expected st=%0d rst=%b",
                         k, state, system_reset, exp_st, (k >= 11));
            end
        end
        btn_n = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step(1);
            exp_st = (cnt < 3) ? 2'd0 : 2'd1;
            n_chk++;
            if (state !== exp_st || system_reset !== (cnt < 3)) begin
                n_err++;
                $display("FAIL release j=%0d: got st=%0d rst=%b, expected st=%0d rst=%b",
                         j, state, system_reset, exp_st, (cnt < 3));
            end
            if (j >= 10 && phase1()) cnt++;
        end
    endtask

    task automatic test_trap();
        logic [1:0] exp_st;
        int cnt = 0;
        while (!phase1()) step(1);
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            n_chk++;
            if ({state, system_reset, trapped, clk_en} !== {2'd2, 1'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL trapped k=%0d: got st=%0d rst=%b trp=%b en=%b, expected st=2 rst=0 trp=1 en=0",
                         k, state, system_reset, trapped, clk_en);
            end
            step(1);
        end
        for (int j = 0; j <= 15; j++) begin
            exp_st = (cnt < 3) ? 2'd0 : 2'd1;
            n_chk++;
            if (state !== exp_st || system_reset !== (cnt < 3) || trapped !== 1'b0) begin
                n_err++;
                $display("FAIL restart j=%0d: got st=%0d rst=%b trp=%b, expected st=%0d rst=%b trp=0",
                         j, state, system_reset, trapped, exp_st, (cnt < 3));
            end
            if (phase1()) cnt++;
            step(1);
        end
    endtask

    task automatic test_no_restart();
        int bad = 0;
        while (((cyc - base2) % DIV) != DIV - 1) step(1);
        n_chk++;
        if (clk_en2 !== 1'b1 || state2 !== 2'd1) begin
            n_err++;
            $display("FAIL norestart_run: got st=%0d en=%b, expected st=1 en=1", state2, clk_en2);
        end
        trap2 = 1'b1;
        step(1);
        trap2 = 1'b0;
        repeat (1000) begin
            step(1);
            if (state2 !== 2'd2 || trapped2 !== 1'b1 || clk_en2 !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL norestart_hold: got %0d cycles out of TRAPPED, expected 0 (final st=%0d)", bad, state2);
        end
        btn_n2 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            if (k == 10) begin
                n_chk++;
                if (state2 !== 2'd2) begin
                    n_err++;
                    $display("FAIL norestart_pre: got st=%0d, expected st=2", state2);
                end
            end
        end
        n_chk++;
        if (state2 !== 2'd0 || system_reset2 !== 1'b1 || trapped2 !== 1'b0) begin
            n_err++;
            $display("FAIL norestart_press: got st=%0d rst=%b trp=%b, expected st=0 rst=1 trp=0",
                     state2, system_reset2, trapped2);
        end
        btn_n2 = 1'b1;
    endtask

    task automatic test_reset_mid();
        while (!phase1()) step(1);
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        step(10);
        n_chk++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL midtrap_pre: got st=%0d, expected st=2", state);
        end
        reset = 1'b1;
        step(1);
        n_chk++;
        if ({state, system_reset, trapped, clk_en} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midtrap_reset: got st=%0d rst=%b trp=%b en=%b, expected st=0 rst=1 trp=0 en=0",
                     state, system_reset, trapped, clk_en);
        end
        test_boot(14);
        reset = 1'b1;
        step(1);
        test_boot(9);
        reset = 1'b1;
        step(1);
        n_chk++;
        if ({state, system_reset, trapped, clk_en} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midhold_reset: got st=%0d rst=%b trp=%b en=%b, expected st=0 rst=1 trp=0 en=0",
                     state, system_reset, trapped, clk_en);
        end
        test_boot(14);
    endtask

    task automatic test_simul();
        int bad = 0;
        while (!phase1()) step(1);
        step(2);
        btn_n = 1'b0;
        step(10);
        n_chk++;
        if (clk_en !== 1'b1 || state !== 2'd1) begin
            n_err++;
            $display("FAIL simul_pre: got st=%0d en=%b, expected st=1 en=1", state, clk_en);
        end
        trap = 1'b1;
        step(1);
        trap = 1'b0;
        n_chk++;
        if (state !== 2'd0 || trapped !== 1'b0 || system_reset !== 1'b1) begin
            n_err++;
            $display("FAIL simul: got st=%0d trp=%b rst=%b, expected st=0 trp=0 rst=1",
                     state, trapped, system_reset);
        end
        repeat (5) begin
            step(1);
            if (state !== 2'd0 || trapped !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL simul_after: got %0d cycles out of HOLD, expected 0", bad);
        end
        btn_n = 1'b1;
        step(30);
    endtask

    task automatic test_random();
        logic [1:0] exp_st;
        logic       exp_en;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            trap  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) btn_n = ~btn_n;
            step(1);
            exp_st = 2'(m_state);
            exp_en = (m_div == DIV - 1) && (m_state != 2) && !reset;
            n_chk++;
            if ({state, system_reset, trapped, clk_en} !==
                {exp_st, (m_state == 0), (m_state == 2), exp_en}) begin
                n_err++;
                $display("FAIL random i=%0d: got st=%0d rst=%b trp=%b en=%b, expected st=%0d rst=%b trp=%b en=%b",
                         i, state, system_reset, trapped, clk_en,
                         exp_st, (m_state == 0), (m_state == 2), exp_en);
            end
        end
        reset = 1'b0;
        trap  = 1'b0;
        btn_n = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        btn_n  = 1'b1;
        btn_n2 = 1'b1;
        trap   = 1'b0;
        trap2  = 1'b0;
        test_reset();
        reset2 = 1'b0;
        base2  = cyc;
        test_boot(14);
        test_glitch();
        test_press();
        test_trap();
        test_no_restart();
        test_reset_mid();
        test_simul();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
